s_araw_fifo_wptr_ctrl: RTL

- Write-side controller of the S_ARAW asynchronous FIFO, in the write clock domain.
- Accepts AR/AW request payloads from the upstream AXI slave-side channel using a valid/ready handshake.
- Drives the write port of the FIFO memory (wdata/waddr/wpush/wfull).
- Keeps binary and Gray write pointers, synchronizes the read-domain Gray pointer, and produces full, almost-full and occupancy status.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/s_araw_fifo_wptr_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer type and Gray/binary conversions used by
// both the write-side and read-side pointer controllers.
package fifo_pkg;

    // Default geometry of the S_ARAW FIFO (DEPTH = 2**FIFO_ADDRSIZE).
    localparam int FIFO_ADDRSIZE   = 4;
    localparam int S_ARAW_DATASIZE = 32;
    localparam int PTR_W           = FIFO_ADDRSIZE + 1;

    // Pointer carries one extra wrap bit above the memory address.
    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer into the wclk domain. The input must be
// Gray-coded (or otherwise single-bit-changing) for a multi-bit WIDTH.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q1;
    logic [WIDTH-1:0] r_q2;

    // Two back-to-back flops resolve metastability before the value is used.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= i_d;
            r_q2 <= r_q1;
        end
    end

    assign o_q = r_q2;

endmodule

// File: rtl/s_araw_fifo_wptr_ctrl.sv
// Write-side controller of the S_ARAW asynchronous FIFO: accepts AR/AW
// payloads on a valid/ready handshake, drives the memory write port, keeps
// binary/Gray write pointers and produces conservative full/occupancy status.
module s_araw_fifo_wptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE  = FIFO_ADDRSIZE,
    parameter int DATASIZE  = S_ARAW_DATASIZE,
    parameter int AF_THRESH = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                s_valid,
    input  logic [DATASIZE-1:0] s_payload,
    output logic                s_ready,
    output logic [DATASIZE-1:0] wdata,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wpush,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wcount,
    output logic [ADDRSIZE:0]   wptr,
    input  logic [ADDRSIZE:0]   rptr
);

    localparam int              DEPTH   = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_P = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0] AF_P    = (ADDRSIZE+1)'(AF_THRESH);

    logic [ADDRSIZE:0] r_wbin;
    logic [ADDRSIZE:0] r_wptr;
    logic [ADDRSIZE:0] r_wcount;
    logic              r_wfull;
    logic              r_walmost_full;
    logic              r_init_done;

    logic [ADDRSIZE:0] w_wq2_rptr;
    logic [ADDRSIZE:0] w_rbin_s;
    logic [ADDRSIZE:0] w_wbinnext;
    logic [ADDRSIZE:0] w_wgraynext;
    logic [ADDRSIZE:0] w_cnt_next;
    logic [ADDRSIZE:0] w_free;
    logic [ADDRSIZE:0] w_full_tgt;
    logic              w_ready;
    logic              w_push;

    // Read pointer crosses into wclk here; w_wq2_rptr is its only consumer.
    sync_2ff #(
        .WIDTH (ADDRSIZE + 1)
    ) u_rptr_sync (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .i_d    (rptr),
        .o_q    (w_wq2_rptr)
    );

    // Ready comes only from registers, so there is no path from s_valid.
    assign w_ready = r_init_done & ~r_wfull;
    assign w_push  = s_valid & w_ready;

    assign w_wbinnext  = r_wbin + {{ADDRSIZE{1'b0}}, w_push};
    assign w_wgraynext = bin2gray(w_wbinnext);
    assign w_rbin_s    = gray2bin(w_wq2_rptr);

    // Occupancy after this cycle's push, against the (stale) synced read side.
    assign w_cnt_next = w_wbinnext - w_rbin_s;
    assign w_free     = DEPTH_P - w_cnt_next;

    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign w_full_tgt = {~w_wq2_rptr[ADDRSIZE:ADDRSIZE-1], w_wq2_rptr[ADDRSIZE-2:0]};

    // Pointer, status and init registers; all clear asynchronously on reset.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_init_done    <= 1'b0;
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wcount       <= '0;
        end else begin
            r_init_done    <= 1'b1;
            r_wbin         <= w_wbinnext;
            r_wptr         <= w_wgraynext;
            r_wfull        <= (w_wgraynext == w_full_tgt);
            r_walmost_full <= (w_free <= AF_P);
            r_wcount       <= w_cnt_next;
        end
    end

    assign s_ready      = w_ready;
    assign wpush        = w_push;
    assign wdata        = s_payload;
    assign waddr        = r_wbin[ADDRSIZE-1:0];
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wcount       = r_wcount;
    assign wptr         = r_wptr;

endmodule
